instr_sequencer: RTL and testbench

- Control stage directly upstream of the instruction fetcher.
- Owns the instruction pointer and steps the core through a fixed FETCH -> DECODE -> EXECUTE cycle.
- Drives the fetcher's pointer and fetch_enable, the decode and execute enables, and accepts branch, stall and halt requests from execute.
- Also keeps a retired-instruction counter for debug and test.

---
 rtl/instr_sequencer.sv | 86 ++++++++
 tb/tb_instr_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - FETCH/DECODE/EXECUTE sequencer owning the instruction pointer
// Enables and halted are registered alongside the state, so they always mirror the state register.
module instr_sequencer #(
  parameter int                   WORD_SIZE    = 16,
  parameter logic [WORD_SIZE-1:0] RESET_VECTOR = '0,
  parameter int                   COUNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  output logic [WORD_SIZE-1:0]   pointer,
  output logic                   fetch_enable,
  output logic                   decode_enable,
  output logic                   exec_enable,
  input  logic                   branch_taken,
  input  logic [WORD_SIZE-1:0]   branch_target,
  input  logic                   stall,
  input  logic                   halt_req,
  output logic                   halted,
  output logic [COUNT_WIDTH-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_HALTED  = 3'd4
  } state_t;

  state_t state;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      pointer       <= RESET_VECTOR;
      retired       <= '0;
      fetch_enable  <= 1'b0;
      decode_enable <= 1'b0;
      exec_enable   <= 1'b0;
      halted        <= 1'b0;
    end else begin
      fetch_enable  <= 1'b0;
      decode_enable <= 1'b0;
      exec_enable   <= 1'b0;
      halted        <= 1'b0;
      case (state)
        S_IDLE: begin
          state        <= S_FETCH;
          fetch_enable <= 1'b1;
        end
        S_FETCH: begin
          state         <= S_DECODE;
          decode_enable <= 1'b1;
        end
        S_DECODE: begin
          state       <= S_EXECUTE;
          exec_enable <= 1'b1;
        end
        S_EXECUTE: begin
          if (stall) begin
            exec_enable <= 1'b1;
          end else begin
            // Retire edge: halt wins over branch, branch over sequential step.
            retired <= retired + COUNT_WIDTH'(1);
            if (halt_req) begin
              state  <= S_HALTED;
              halted <= 1'b1;
            end else begin
              state        <= S_FETCH;
              fetch_enable <= 1'b1;
              if (branch_taken) pointer <= branch_target;
              else              pointer <= pointer + WORD_SIZE'(1);
            end
          end
        end
        S_HALTED: begin
          halted <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - scoreboard bench for instr_sequencer with an instruction-level model
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        branch_taken, stall, halt_req;
  logic [15:0] branch_target;

  logic [15:0] pointer, pointer_w;
  logic        fetch_enable, decode_enable, exec_enable, halted;
  logic        fetch_enable_w, decode_enable_w, exec_enable_w, halted_w;
  logic [15:0] retired;
  logic [2:0]  retired_w;

  instr_sequencer dut (
    .clk(clk), .reset_n(reset_n), .pointer(pointer),
    .fetch_enable(fetch_enable), .decode_enable(decode_enable), .exec_enable(exec_enable),
    .branch_taken(branch_taken), .branch_target(branch_target), .stall(stall),
    .halt_req(halt_req), .halted(halted), .retired(retired)
  );

  instr_sequencer #(.WORD_SIZE(16), .RESET_VECTOR(16'hFFFE), .COUNT_WIDTH(3)) dut_w (
    .clk(clk), .reset_n(reset_n), .pointer(pointer_w),
    .fetch_enable(fetch_enable_w), .decode_enable(decode_enable_w), .exec_enable(exec_enable_w),
    .branch_taken(branch_taken), .branch_target(branch_target), .stall(stall),
    .halt_req(halt_req), .halted(halted_w), .retired(retired_w)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          halt;
    logic [15:0] p1;
    logic [15:0] p2;
    int unsigned ret;
  } rec_t;

  rec_t        exp_q[$];
  int          exp_exec[$];
  int          checks = 0;
  int          passed = 0;
  bit          flush = 1'b1;
  logic [15:0] m_p1, m_p2;
  int unsigned m_ret;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic fail_event(input string name);
    checks++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Monitor: samples just after each rising edge, decoupled from the driver.
  int          run = 0;
  bit          prev_fetch = 0, prev_dec = 0, prev_halt = 0;
  logic [15:0] cur_p1 = 0, cur_p2 = 0;
  int unsigned cur_ret = 0;

  always @(posedge clk) begin
    rec_t r;
    int   e;
    #1;
    if (flush) begin
      run = 0;
    end else begin
      if (prev_fetch) check("decode_after_fetch", 32'({fetch_enable, decode_enable, exec_enable}), 32'b010);
      if (prev_dec)   check("exec_after_decode",  32'({fetch_enable, decode_enable, exec_enable}), 32'b001);
      if (fetch_enable) begin
        if (exp_q.size() == 0) fail_event("unexpected_fetch");
        else begin
          r = exp_q.pop_front();
          if (r.halt) fail_event("fetch_instead_of_halt");
          else begin
            check("fetch_ptr",     32'(pointer),        32'(r.p1));
            check("fetch_ptr_w",   32'(pointer_w),      32'(r.p2));
            check("fetch_ret",     32'(retired),        32'(r.ret % 65536));
            check("fetch_ret_w",   32'(retired_w),      32'(r.ret % 8));
            check("fetch_en_w",    32'(fetch_enable_w), 32'd1);
            cur_p1 = r.p1; cur_p2 = r.p2; cur_ret = r.ret;
          end
        end
      end
      if (exec_enable) begin
        run++;
        check("exec_ptr_hold", 32'(pointer),   32'(cur_p1));
        check("exec_ret_hold", 32'(retired),   32'(cur_ret % 65536));
        check("exec_ptr_w",    32'(pointer_w), 32'(cur_p2));
      end else if (run > 0) begin
        if (exp_exec.size() == 0) fail_event("unexpected_exec_run");
        else begin
          e = exp_exec.pop_front();
          check("exec_len", 32'(run), 32'(e));
        end
        check("next_after_retire", 32'(fetch_enable | halted), 32'd1);
        run = 0;
      end
      if (halted && !prev_halt) begin
        if (exp_q.size() == 0) fail_event("unexpected_halt");
        else begin
          r = exp_q.pop_front();
          if (!r.halt) fail_event("halt_instead_of_fetch");
          else begin
            check("halt_ptr",   32'(pointer),   32'(r.p1));
            check("halt_ptr_w", 32'(pointer_w), 32'(r.p2));
            check("halt_ret",   32'(retired),   32'(r.ret % 65536));
            check("halt_ret_w", 32'(retired_w), 32'(r.ret % 8));
          end
        end
      end
    end
    prev_fetch = fetch_enable;
    prev_dec   = decode_enable;
    prev_halt  = halted;
  end

  task automatic randomize_dc();
    stall         = 1'($urandom);
    branch_taken  = 1'($urandom);
    halt_req      = 1'($urandom);
    branch_target = 16'($urandom);
  endtask

  task automatic push_fetch();
    rec_t r;
    r.halt = 0; r.p1 = m_p1; r.p2 = m_p2; r.ret = m_ret;
    exp_q.push_back(r);
  endtask

  // Called on a falling edge; leaves on the falling edge of the first FETCH cycle.
  task automatic do_reset();
    flush   = 1'b1;
    reset_n = 1'b0;
    randomize_dc();
    @(negedge clk);
    check("rst_ptr",     32'(pointer),   32'h0000);
    check("rst_ptr_w",   32'(pointer_w), 32'hFFFE);
    check("rst_ret",     32'(retired),   32'd0);
    check("rst_ret_w",   32'(retired_w), 32'd0);
    check("rst_enables", 32'({fetch_enable, decode_enable, exec_enable, halted}), 32'd0);
    exp_q.delete();
    exp_exec.delete();
    m_p1 = 16'h0000; m_p2 = 16'hFFFE; m_ret = 0;
    push_fetch();
    reset_n = 1'b1;
    flush   = 1'b0;
    randomize_dc();
    @(negedge clk);
    check("first_fetch", 32'(fetch_enable), 32'd1);
  endtask

  task automatic wait_exec(output bit ok);
    ok = 0;
    for (int i = 0; i < 12; i++) begin
      if (exec_enable) begin ok = 1; break; end
      randomize_dc();
      @(negedge clk);
    end
    if (!ok) fail_event("exec_wait_timeout");
  endtask

  task automatic run_instr(input int k, input bit br, input logic [15:0] tgt, input bit hlt);
    bit ok;
    rec_t r;
    wait_exec(ok);
    if (!ok) return;
    for (int i = 0; i < k; i++) begin
      randomize_dc();
      stall = 1'b1;
      @(negedge clk);
    end
    stall = 1'b0; branch_taken = br; halt_req = hlt; branch_target = tgt;
    m_ret++;
    exp_exec.push_back(k + 1);
    if (hlt) begin
      r.halt = 1; r.p1 = m_p1; r.p2 = m_p2; r.ret = m_ret;
      exp_q.push_back(r);
    end else begin
      if (br) begin m_p1 = tgt; m_p2 = tgt; end
      else    begin m_p1 = m_p1 + 16'd1; m_p2 = m_p2 + 16'd1; end
      push_fetch();
    end
    @(negedge clk);
    randomize_dc();
  endtask

  initial begin
    bit ok;
    int k;
    logic [15:0] t;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int k;
    logic [15:0] t;
    randomize_dc();
    @(negedge clk);
    do_reset();
    run_instr(4, 0, 16'h0, 0);
    run_instr(0, 1, 16'h0040, 0);
    run_instr(0, 0, 16'h0, 0);
    for (int n = 0; n < 50; n++) begin
      k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      case ($urandom_range(0, 3))
        0:       t = m_p1;
        1:       t = 16'hFFFF;
        default: t = 16'($urandom);
      endcase
      run_instr(k, ($urandom_range(0, 2) == 0), t, 0);
    end

    // Reset arriving while EXECUTE is stalled.
    wait_exec(ok);
    stall = 1'b1;
    @(negedge clk);
    stall = 1'b1;
    do_reset();

    run_instr(0, 0, 16'h0, 0);
    run_instr(0, 0, 16'h0, 0);
    run_instr(0, 1, 16'h0010, 1);
    check("halted_flag", 32'(halted),    32'd1);
    check("halted_ptr",  32'(pointer),   32'd2);
    check("halted_ptr_w",32'(pointer_w), 32'h0000);
    check("halted_ret",  32'(retired),   32'd3);
    for (int i = 0; i < 20; i++) begin
      randomize_dc();
      @(negedge clk);
      check("halt_enables", 32'({fetch_enable, decode_enable, exec_enable, halted}), 32'b0001);
      check("halt_ptr_hold", 32'(pointer), 32'd2);
    end

    do_reset();
    for (int n = 0; n < 9; n++)
      run_instr(int'($urandom_range(0, 1)), 1'($urandom), 16'($urandom), 0);
    repeat (2) @(negedge clk);
    check("queues_drained", 32'(exp_q.size() + exp_exec.size()), 32'd0);
    check("ret_w_wrap",     32'(retired_w), 32'(9 % 8));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
